ps2_text_cursor_ctrl: RTL and testbench

Text-entry controller between the PS/2 keyboard decoder and the VGA character display. It consumes decoded ASCII characters, keeps the text cursor on a 16×12 grid of 40-pixel cells, and issues single-cycle writes into the display's character buffer RAM. It also sequences a full-screen clear sweep after reset and on ESC. The VGA pattern generator reads `oCur_X` and `oCur_Y` to draw the cursor.

---
 rtl/ps2_text_cursor_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ps2_text_cursor_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_text_cursor_ctrl.sv
// Text-entry controller: turns decoded ASCII characters into character-RAM
// writes, tracks the text cursor on a COLS x ROWS grid, and sweeps the whole
// buffer with BLANK after reset and on ESC.
module ps2_text_cursor_ctrl #(
  parameter int unsigned COLS  = 16,
  parameter int unsigned ROWS  = 12,
  parameter int unsigned CELL  = 40,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iAscii,
  input  logic       iValid,
  output logic       oReady,
  output logic       oWr_En,
  output logic [7:0] oWr_Addr,
  output logic [7:0] oWr_Data,
  output logic [9:0] oCur_X,
  output logic [9:0] oCur_Y
);

  localparam int unsigned AW    = 8;
  localparam int unsigned PW    = 10;
  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CELLS = COLS * ROWS;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_ESC = 8'h1B;
  localparam logic [7:0] CH_LO  = 8'h20;
  localparam logic [7:0] CH_HI  = 8'h7E;

  localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);
  localparam logic [AW-1:0] COLS_A    = AW'(COLS);
  localparam logic [PW-1:0] CELL_P    = PW'(CELL);

  logic [0:0]    state_q,   state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [CW-1:0] col_q,     col_d;
  logic [RW-1:0] row_q,     row_d;
  logic          ready_q,   ready_d;
  logic          wr_en_q,   wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [PW-1:0] cur_x_q,   cur_x_d;
  logic [PW-1:0] cur_y_q,   cur_y_d;

  logic          accept;
  logic [CW-1:0] adv_col, ret_col;
  logic [RW-1:0] adv_row, ret_row, nl_row;
  logic [AW-1:0] cur_addr, ret_addr;

  // Cursor neighbours: next cell (advance), previous cell (retreat), next line
  always_comb begin
    adv_col = col_q + CW'(1);
    adv_row = row_q;
    if (col_q == COL_MAX) begin
      adv_col = '0;
      adv_row = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
    end

    ret_col = col_q;
    ret_row = row_q;
    if (col_q != '0) begin
      ret_col = col_q - CW'(1);
    end else if (row_q != '0) begin
      ret_col = COL_MAX;
      ret_row = row_q - RW'(1);
    end

    nl_row   = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
    cur_addr = AW'(row_q) * COLS_A + AW'(col_q);
    ret_addr = AW'(ret_row) * COLS_A + AW'(ret_col);
  end

  assign accept = (state_q == ST_IDLE) && iValid && ready_q;

  // Next-state and registered-output logic for the CLEAR/IDLE controller
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    ready_d   = ready_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_cnt_q;
        wr_data_d = BLANK;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          if (iAscii >= CH_LO && iAscii <= CH_HI) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_data_d = iAscii;
            col_d     = adv_col;
            row_d     = adv_row;
          end else if (iAscii == CH_BS) begin
            // At the origin the retreat is a no-op but the blank still lands at 0
            wr_en_d   = 1'b1;
            wr_addr_d = ret_addr;
            wr_data_d = BLANK;
            col_d     = ret_col;
            row_d     = ret_row;
          end else if (iAscii == CH_CR) begin
            col_d = '0;
            row_d = nl_row;
          end else if (iAscii == CH_ESC) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
            col_d     = '0;
            row_d     = '0;
            ready_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    cur_x_d = PW'(col_d) * CELL_P;
    cur_y_d = PW'(row_d) * CELL_P;
  end

  // State and output registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
    end
  end

  assign oReady   = ready_q;
  assign oWr_En   = wr_en_q;
  assign oWr_Addr = wr_addr_q;
  assign oWr_Data = wr_data_q;
  assign oCur_X   = cur_x_q;
  assign oCur_Y   = cur_y_q;

endmodule

// File: tb/tb_ps2_text_cursor_ctrl.sv
// Directed bench for ps2_text_cursor_ctrl: clear sweeps, printable writes,
// backspace/enter wrap cases, ignored codes, ESC and mid-sweep reset.
module tb_ps2_text_cursor_ctrl;

  logic       iCLK;
  logic       iRST_N;
  logic [7:0] iAscii;
  logic       iValid;
  logic       oReady;
  logic       oWr_En;
  logic [7:0] oWr_Addr;
  logic [7:0] oWr_Data;
  logic [9:0] oCur_X;
  logic [9:0] oCur_Y;

  int vec_cnt = 0;
  int err_cnt = 0;

  ps2_text_cursor_ctrl dut (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iAscii   (iAscii),
    .iValid   (iValid),
    .oReady   (oReady),
    .oWr_En   (oWr_En),
    .oWr_Addr (oWr_Addr),
    .oWr_Data (oWr_Data),
    .oCur_X   (oCur_X),
    .oCur_Y   (oCur_Y)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Single comparison point: counts every vector and reports a miscompare
  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_cur(input string tag, input int unsigned x, input int unsigned y);
    chk({tag, "_x"}, oCur_X, x);
    chk({tag, "_y"}, oCur_Y, y);
  endtask

  task automatic chk_wr(input string tag, input int unsigned addr, input int unsigned data);
    chk({tag, "_en"}, oWr_En, 1);
    chk({tag, "_addr"}, oWr_Addr, addr);
    chk({tag, "_data"}, oWr_Data, data);
  endtask

  // Present one character for one edge, then sample just after that edge
  task automatic send(input logic [7:0] code);
    iAscii = code;
    iValid = 1'b1;
    @(posedge iCLK);
    #1;
    iValid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge iCLK);
    #1;
  endtask

  // Check n sweep writes starting at address 0; optionally pulse iValid meanwhile
  task automatic run_sweep(input int n, input bit pulses);
    for (int i = 0; i < n; i++) begin
      if (pulses && ((i % 37) == 5 || i == 191)) begin
        iAscii = 8'h51;
        iValid = 1'b1;
      end
      @(posedge iCLK);
      #1;
      iValid = 1'b0;
      chk_wr("sweep", i, 8'h20);
      chk("sweep_rdy", oReady, (i == 191) ? 1 : 0);
      chk_cur("sweep_cur", 0, 0);
    end
  endtask

  initial begin
    iRST_N = 1'b0;
    iAscii = 8'h00;
    iValid = 1'b0;
    #12;
    chk("rst_rdy", oReady, 0);
    chk("rst_en", oWr_En, 0);
    chk("rst_addr", oWr_Addr, 0);
    chk("rst_data", oWr_Data, 0);
    chk_cur("rst_cur", 0, 0);

    // Release between edges; first edge after release writes address 0
    iRST_N = 1'b1;
    run_sweep(192, 1'b0);
    idle_cycle();
    chk("post_sweep_en", oWr_En, 0);
    chk("post_sweep_rdy", oReady, 1);

    // First character
    send(8'h41);
    chk_wr("a41", 0, 8'h41);
    chk_cur("a41_cur", 40, 0);
    idle_cycle();
    chk("a41_idle_en", oWr_En, 0);

    // Back to origin, then 16 back-to-back printables fill row 0
    send(8'h08);
    chk_wr("bs_back", 0, 8'h20);
    chk_cur("bs_back_cur", 0, 0);
    for (int i = 0; i < 16; i++) begin
      send(8'h61 + 8'(i));
      chk_wr("row0", i, 8'h61 + i);
    end
    chk_cur("row0_end", 0, 40);
    send(8'h7A);
    chk_wr("char17", 16, 8'h7A);
    chk_cur("char17_cur", 40, 40);

    // Retreat to (0,1), then across the row boundary to (15,0)
    send(8'h08);
    chk_wr("bs_16", 16, 8'h20);
    chk_cur("bs_16_cur", 0, 40);
    send(8'h08);
    chk_wr("bs_row", 15, 8'h20);
    chk_cur("bs_row_cur", 600, 0);
    for (int i = 14; i >= 0; i--) begin
      send(8'h08);
      chk("bs_walk_addr", oWr_Addr, i);
    end
    chk_cur("bs_walk_cur", 0, 0);
    send(8'h08);
    chk_wr("bs_origin", 0, 8'h20);
    chk_cur("bs_origin_cur", 0, 0);

    // Enter down to row 11, fill it, last cell wraps to origin
    for (int i = 1; i <= 11; i++) begin
      send(8'h0D);
      chk("cr_en", oWr_En, 0);
      chk_cur("cr_cur", 0, i * 40);
    end
    for (int i = 0; i < 15; i++) begin
      send(8'h30);
      chk("row11_addr", oWr_Addr, 176 + i);
    end
    chk_cur("row11_pre", 600, 440);
    send(8'h7E);
    chk_wr("last_cell", 191, 8'h7E);
    chk_cur("last_cell_cur", 0, 0);

    // Enter on row 11 wraps to origin without a write
    for (int i = 0; i < 11; i++) send(8'h0D);
    chk_cur("cr11_pre", 0, 440);
    send(8'h0D);
    chk("cr_wrap_en", oWr_En, 0);
    chk_cur("cr_wrap_cur", 0, 0);

    // Non-printable codes are consumed with no effect
    send(8'h42);
    chk_cur("pre_7f", 40, 0);
    send(8'h7F);
    chk("c7f_en", oWr_En, 0);
    chk_cur("c7f_cur", 40, 0);
    send(8'h01);
    chk("c01_en", oWr_En, 0);
    chk_cur("c01_cur", 40, 0);

    // ESC after a few characters; iValid pulses during the sweep are dropped
    send(8'h43);
    send(8'h44);
    chk_cur("pre_esc", 120, 0);
    send(8'h1B);
    chk("esc_rdy", oReady, 0);
    chk("esc_en", oWr_En, 0);
    chk_cur("esc_cur", 0, 0);
    run_sweep(192, 1'b1);
    send(8'h45);
    chk_wr("after_esc", 0, 8'h45);
    chk_cur("after_esc_cur", 40, 0);

    // ESC again, reset mid-sweep at address 100, sweep restarts from 0
    send(8'h1B);
    run_sweep(101, 1'b0);
    #2;
    iRST_N = 1'b0;
    #1;
    chk("mid_rst_rdy", oReady, 0);
    chk("mid_rst_en", oWr_En, 0);
    chk("mid_rst_addr", oWr_Addr, 0);
    chk("mid_rst_data", oWr_Data, 0);
    chk_cur("mid_rst_cur", 0, 0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    run_sweep(192, 1'b0);
    idle_cycle();
    chk("final_en", oWr_En, 0);
    chk("final_rdy", oReady, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
